// File: rtl/state_update_seq.sv
// Sequential EKF prediction stage: one shared Q-format multiplier over nine steps, then a single accumulate.
// Define STATE_UPDATE_SAT_EN to make every multiply, add and negate saturate instead of wrapping.
module state_update_seq #(
  parameter int N            = 32,
  parameter int Q            = 18,
  parameter int TS_LS        = 2621,
  parameter int RS_TS_LS     = 1311,
  parameter int LAMBDA_TS_LS = 262,
  parameter int T_Q          = 3,
  parameter int PI_Q         = 823550,
  parameter int TWO_PI_Q     = 1647099
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [N-1:0] ialpha_i,
  input  logic [N-1:0] ibeta_i,
  input  logic [N-1:0] valpha_i,
  input  logic [N-1:0] vbeta_i,
  input  logic [N-1:0] omega_i,
  input  logic [N-1:0] theta_i,
  input  logic [N-1:0] stheta_i,
  input  logic [N-1:0] ctheta_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] ialphae_o,
  output logic [N-1:0] ibetae_o,
  output logic [N-1:0] omegae_o,
  output logic [N-1:0] thetae_o,
  output logic [N-1:0] fa_omega_o,
  output logic [N-1:0] fa_theta_o,
  output logic [N-1:0] fb_omega_o,
  output logic [N-1:0] fb_theta_o,
  output logic         ovf_o
);

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

  localparam logic signed [N-1:0]   C_TS    = N'(TS_LS);
  localparam logic signed [N-1:0]   C_RS    = N'(RS_TS_LS);
  localparam logic signed [N-1:0]   C_LAM   = N'(LAMBDA_TS_LS);
  localparam logic signed [N-1:0]   C_T     = N'(T_Q);
  localparam logic signed [N-1:0]   PI_S    = N'(PI_Q);
  localparam logic signed [N-1:0]   NPI_S   = N'(-PI_Q);
  localparam logic signed [N-1:0]   TWOPI_S = N'(TWO_PI_Q);
  localparam logic signed [2*N-1:0] MAX_W   = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MIN_W   = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  // Result is {overflow flag, N-bit value}; the value wraps or clamps by build option.
  function automatic logic [N:0] fit_f(input logic signed [2*N-1:0] v);
    logic             o;
    logic [N-1:0]     r;
    o = (v > MAX_W) || (v < MIN_W);
    r = v[N-1:0];
`ifdef STATE_UPDATE_SAT_EN
    if (v > MAX_W)      r = MAX_W[N-1:0];
    else if (v < MIN_W) r = MIN_W[N-1:0];
`endif
    return {o, r};
  endfunction

  function automatic logic [N:0] mul_f(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    logic signed [2*N-1:0] ax, bx;
    ax = a;
    bx = b;
    return fit_f((ax * bx) >>> Q);
  endfunction

  function automatic logic [N:0] add_f(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    logic signed [2*N-1:0] ax, bx;
    ax = a;
    bx = b;
    return fit_f(ax + bx);
  endfunction

  function automatic logic [N:0] sub_f(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    logic signed [2*N-1:0] ax, bx;
    ax = a;
    bx = b;
    return fit_f(ax - bx);
  endfunction

  function automatic logic [N:0] neg_f(input logic signed [N-1:0] a);
    logic signed [2*N-1:0] ax;
    ax = a;
    return fit_f(-ax);
  endfunction

  state_t                state_q;
  logic [3:0]            k_q;
  logic signed [N-1:0]   ia_q, ib_q, va_q, vb_q, om_q, th_q, st_q, ct_q;
  logic signed [N-1:0]   m_q [9];

  logic signed [N-1:0]   mul_a_d, mul_b_d, t_d;
  logic [N:0]            mul_d, ia1_d, ia2_d, ia3_d, ib1_d, ib2_d, ib3_d, t_r_d, th_d, fbo_d;
  logic                  acc_ovf_d;

  // Operand select for the shared multiplier; m3 and m7 reuse the products of the previous step.
  always_comb begin
    mul_a_d = om_q;
    mul_b_d = C_T;
    case (k_q)
      4'd0:    begin mul_a_d = va_q; mul_b_d = C_TS;  end
      4'd1:    begin mul_a_d = ia_q; mul_b_d = C_RS;  end
      4'd2:    begin mul_a_d = st_q; mul_b_d = C_LAM; end
      4'd3:    begin mul_a_d = om_q; mul_b_d = m_q[2]; end
      4'd4:    begin mul_a_d = vb_q; mul_b_d = C_TS;  end
      4'd5:    begin mul_a_d = ib_q; mul_b_d = C_RS;  end
      4'd6:    begin mul_a_d = ct_q; mul_b_d = C_LAM; end
      4'd7:    begin mul_a_d = om_q; mul_b_d = m_q[6]; end
      default: begin mul_a_d = om_q; mul_b_d = C_T;   end
    endcase
    mul_d = mul_f(mul_a_d, mul_b_d);
  end

  always_comb begin
    ia1_d = add_f(ia_q, m_q[0]);
    ia2_d = sub_f(ia1_d[N-1:0], m_q[1]);
    ia3_d = add_f(ia2_d[N-1:0], m_q[3]);
    ib1_d = add_f(ib_q, m_q[4]);
    ib2_d = sub_f(ib1_d[N-1:0], m_q[5]);
    ib3_d = sub_f(ib2_d[N-1:0], m_q[7]);
    fbo_d = neg_f(m_q[6]);
    t_r_d = add_f(th_q, m_q[8]);
    t_d   = t_r_d[N-1:0];
    // A single 2*pi correction keeps the angle in [-pi, pi) for one-step advances.
    if (t_d >= PI_S)      th_d = sub_f(t_d, TWOPI_S);
    else if (t_d < NPI_S) th_d = add_f(t_d, TWOPI_S);
    else                  th_d = {1'b0, t_d};
    acc_ovf_d = ia1_d[N] | ia2_d[N] | ia3_d[N] | ib1_d[N] | ib2_d[N] | ib3_d[N] |
                fbo_d[N] | t_r_d[N] | th_d[N];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= 4'd0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ovf_o      <= 1'b0;
      ialphae_o  <= '0;
      ibetae_o   <= '0;
      omegae_o   <= '0;
      thetae_o   <= '0;
      fa_omega_o <= '0;
      fa_theta_o <= '0;
      fb_omega_o <= '0;
      fb_theta_o <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            ia_q    <= ialpha_i;
            ib_q    <= ibeta_i;
            va_q    <= valpha_i;
            vb_q    <= vbeta_i;
            om_q    <= omega_i;
            th_q    <= theta_i;
            st_q    <= stheta_i;
            ct_q    <= ctheta_i;
            k_q     <= 4'd0;
            busy_o  <= 1'b1;
            ovf_o   <= 1'b0;
            state_q <= MUL;
          end else begin
            state_q <= IDLE;
          end
        end
        MUL: begin
          m_q[k_q] <= mul_d[N-1:0];
          ovf_o    <= ovf_o | mul_d[N];
          k_q      <= k_q + 4'd1;
          if (k_q == 4'd8) state_q <= ACC;
        end
        ACC: begin
          ialphae_o  <= ia3_d[N-1:0];
          ibetae_o   <= ib3_d[N-1:0];
          omegae_o   <= om_q;
          thetae_o   <= th_d[N-1:0];
          fa_omega_o <= m_q[2];
          fa_theta_o <= m_q[7];
          fb_omega_o <= fbo_d[N-1:0];
          fb_theta_o <= m_q[3];
          ovf_o      <= ovf_o | acc_ovf_d;
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
          state_q    <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
